uart_tx_serializer: RTL and testbench

Byte-to-serial UART transmitter: the stage that produces the `serial_in` line the receive block samples. Accepts parallel words over a valid/ready handshake, frames each as start bit, LSB-first data and stop bit(s), and drives a single serial line at `P_BAUD` from the 5 MHz system clock. Used on the loopback/test side of the RS232 design and as the host-facing transmitter.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_gen.sv | 33 +++
 rtl/uart_tx_serializer.sv | 150 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, state encoding and bit-period helper,
// used by the transmit and receive blocks.
package uart_pkg;

  localparam int unsigned LP_PRESCALE_W = 16;
  localparam int unsigned LP_BIT_CNT_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_t;

  // System clocks per UART bit, truncating division
  function automatic int unsigned bit_cycles(input int unsigned sys_clk_hz,
                                             input int unsigned baud);
    return sys_clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running bit-period prescaler with synchronous clear;
// bit_tick marks the last clock of each bit period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned P_SYS_CLK_HZ = 5000000,
  parameter int unsigned P_BAUD       = 9600
) (
  input  logic CLK,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned LP_BIT_CYCLES = bit_cycles(P_SYS_CLK_HZ, P_BAUD);
  localparam logic [LP_PRESCALE_W-1:0] LP_LAST = LP_PRESCALE_W'(LP_BIT_CYCLES - 1);

  logic [LP_PRESCALE_W-1:0] prescale;

  // Prescaler: restart on clear, wrap after the last cycle of a bit
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      prescale <= '0;
    end else if (clear || bit_tick) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + LP_PRESCALE_W'(1);
    end
  end

  assign bit_tick = (prescale == LP_LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: valid/ready word in, framed LSB-first UART line out.
// Optional even parity bit after the data bits when UART_TX_PARITY_EN is defined.
// Outputs are flops loaded from the next-state view, so they change on the
// accepting edge together with the state.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned P_UART_WIDTH = 8,
  parameter int unsigned P_BAUD       = 9600,
  parameter int unsigned P_SYS_CLK_HZ = 5000000,
  parameter int unsigned P_STOP_BITS  = 1
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic [P_UART_WIDTH-1:0] data_in,
  input  logic                    data_valid,
  output logic                    ready,
  output logic                    serial_out,
  output logic                    busy
);

  localparam logic [LP_BIT_CNT_W-1:0] LP_LAST_BIT  = LP_BIT_CNT_W'(P_UART_WIDTH - 1);
  localparam logic [LP_BIT_CNT_W-1:0] LP_LAST_STOP = LP_BIT_CNT_W'(P_STOP_BITS - 1);

  uart_state_t             state, state_next;
  logic [P_UART_WIDTH-1:0] shift_reg, shift_next;
  logic [LP_BIT_CNT_W-1:0] bit_cnt, bit_cnt_next;
  logic                    bit_tick;
  logic                    accept;
  logic                    serial_d, ready_d, busy_d;

  assign accept = (state == S_IDLE) && ready && data_valid;

  uart_baud_gen #(
    .P_SYS_CLK_HZ (P_SYS_CLK_HZ),
    .P_BAUD       (P_BAUD)
  ) u_baud_gen (
    .CLK      (CLK),
    .reset    (reset),
    .clear    (accept),
    .bit_tick (bit_tick)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_q;

  // Even parity of the accepted word, held for the parity bit
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^data_in;
    end
  end
`endif

  // State and datapath registers
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= bit_cnt_next;
    end
  end

  // Next-state, shift register and bit/stop counter
  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next   = S_START;
          shift_next   = data_in;
          bit_cnt_next = '0;
        end
      end
      S_START: begin
        if (bit_tick) state_next = S_DATA;
      end
      S_DATA: begin
        if (bit_tick) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt == LP_LAST_BIT) begin
            bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next   = S_PARITY;
`else
            state_next   = S_STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt + LP_BIT_CNT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_tick) state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_tick) begin
          if (bit_cnt == LP_LAST_STOP) begin
            bit_cnt_next = '0;
            state_next   = S_IDLE;
          end else begin
            bit_cnt_next = bit_cnt + LP_BIT_CNT_W'(1);
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output values for the state being entered
  always_comb begin
    serial_d = 1'b1;
    ready_d  = (state_next == S_IDLE);
    busy_d   = (state_next != S_IDLE);
    case (state_next)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: serial_d = parity_q;
`endif
      default:  serial_d = 1'b1;
    endcase
  end

  // Output registers; reset forces the line high at once
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      serial_out <= 1'b1;
      ready      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      serial_out <= serial_d;
      ready      <= ready_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed frame checks on a 1-stop and a 2-stop instance.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  localparam int LP_BIT = 520;   // 5_000_000 / 9600

  logic       CLK = 1'b0;
  logic       reset;
  logic [7:0] din1, din2;
  logic       dv1, dv2;
  logic       rdy1, rdy2, so1, so2, busy1, busy2;
  logic       sel = 1'b0;
  logic       line_s, ready_s, busy_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #100 CLK = ~CLK;

  uart_tx_serializer u_dut1 (
    .CLK        (CLK),
    .reset      (reset),
    .data_in    (din1),
    .data_valid (dv1),
    .ready      (rdy1),
    .serial_out (so1),
    .busy       (busy1)
  );

  uart_tx_serializer #(.P_STOP_BITS(2)) u_dut2 (
    .CLK        (CLK),
    .reset      (reset),
    .data_in    (din2),
    .data_valid (dv2),
    .ready      (rdy2),
    .serial_out (so2),
    .busy       (busy2)
  );

  assign line_s  = sel ? so2   : so1;
  assign ready_s = sel ? rdy2  : rdy1;
  assign busy_s  = sel ? busy2 : busy1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic v);
    if (sel) begin din2 = d; dv2 = v; end
    else     begin din1 = d; dv1 = v; end
  endtask

  // Offer a word, wait for the accepting edge, then scramble data_in
  task automatic send(input logic [7:0] d, input logic keep);
    int waited;
    @(negedge CLK);
    drive(d, 1'b1);
    waited = 0;
    while (!ready_s && waited < 20000) begin
      @(negedge CLK);
      waited++;
    end
    check("accept_ready", 32'(ready_s), 32'd1);
    @(posedge CLK);
    #1 drive(~d, keep);
  endtask

  // Called just after the accepting edge; checks every bit's level and length
  task automatic check_frame(input logic [7:0] d);
    logic exp_bits[$];
    int   nstop;
    int   good;
    nstop = sel ? 2 : 1;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    exp_bits.push_back(^d);
`endif
    for (int s = 0; s < nstop; s++) exp_bits.push_back(1'b1);
    for (int b = 0; b < exp_bits.size(); b++) begin
      good = 0;
      for (int c = 0; c < LP_BIT; c++) begin
        @(negedge CLK);
        if (b == 0 && c == 0) begin
          check("busy_rise", 32'(busy_s), 32'd1);
          check("ready_fall", 32'(ready_s), 32'd0);
        end
        if (line_s === exp_bits[b]) good++;
        if (b == exp_bits.size() - 1 && c == LP_BIT - 1)
          check("ready_low_last_cycle", 32'(ready_s), 32'd0);
      end
      check($sformatf("d%02h_bit%0d_cycles", d, b), 32'(good), 32'(LP_BIT));
    end
    @(negedge CLK);
    check("ready_back", 32'(ready_s), 32'd1);
    check("busy_idle", 32'(busy_s), 32'd0);
    check("line_idle", 32'(line_s), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    din1 = '0; dv1 = 1'b0;
    din2 = '0; dv2 = 1'b0;

    // Reset values
    repeat (3) @(negedge CLK);
    check("rst_serial", 32'(so1), 32'd1);
    check("rst_ready", 32'(rdy1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_ready2", 32'(rdy2), 32'd0);
    reset = 1'b0;
    @(negedge CLK);
    check("rel_ready", 32'(rdy1), 32'd1);
    check("rel_serial", 32'(so1), 32'd1);
    check("rel_busy", 32'(busy1), 32'd0);
    check("rel_ready2", 32'(rdy2), 32'd1);

    // Single frame 0xA5
    send(8'hA5, 1'b0);
    check_frame(8'hA5);

    // Valid held high: 0x00 then 0xFF back to back
    send(8'h00, 1'b1);
    check_frame(8'h00);
    @(posedge CLK);
    #1 dv1 = 1'b0;
    check_frame(8'hFF);

    // Reset mid-frame during data bit 3 of 0xC3 (bit 3 = 0)
    send(8'hC3, 1'b0);
    repeat (4 * LP_BIT + LP_BIT / 2) @(negedge CLK);
    check("pre_rst_line", 32'(so1), 32'd0);
    check("pre_rst_busy", 32'(busy1), 32'd1);
    #20 reset = 1'b1;
    #1;
    check("async_rst_line", 32'(so1), 32'd1);
    check("async_rst_busy", 32'(busy1), 32'd0);
    check("async_rst_ready", 32'(rdy1), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    check("post_rst_ready", 32'(rdy1), 32'd1);
    send(8'h5A, 1'b0);
    check_frame(8'h5A);

    // Two stop bits, 0x55
    sel = 1'b1;
    send(8'h55, 1'b0);
    check_frame(8'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
